// File: rtl/gobang_turn_ctrl.sv
// Gobang game sequencer. It alternates AI engine moves and human moves, validates each
// stone, and scans four directions around the last stone for five in a row.
module gobang_turn_ctrl #(
  parameter int AI_TIMEOUT = 2048,
  parameter int BOARD_N    = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           mv_valid,
  input  logic [3:0]                     mv_x,
  input  logic [3:0]                     mv_y,
  output logic                           mv_ready,
  output logic                           mv_reject,
  output logic [BOARD_N*BOARD_N-1:0]     human_board,
  input  logic [BOARD_N*BOARD_N-1:0]     ai_board,
  output logic                           ai_rst_n,
  output logic                           ai_en,
  input  logic                           ai_finish,
  input  logic [3:0]                     ai_x,
  input  logic [3:0]                     ai_y,
  output logic [3:0]                     last_x,
  output logic [3:0]                     last_y,
  output logic [7:0]                     move_cnt,
  output logic [1:0]                     winner,
  output logic                           game_over,
  output logic                           err
);

  localparam int         CELLS    = BOARD_N * BOARD_N;
  localparam logic [3:0] MAX_RC   = 4'(BOARD_N - 1);
  localparam logic [7:0] FULL_CNT = 8'(CELLS);

  typedef enum logic [2:0] {IDLE, AI_RST, AI_ARM, AI_WAIT, CHK, HUM_WAIT, OVER} state_t;

  state_t      state_r;
  logic [1:0]  dir_r;
  logic        who_r;
  logic [11:0] toCnt_r;

  logic [7:0]       mvIdx_s;
  logic [7:0]       aiIdx_s;
  logic [7:0]       cntInc_s;
  logic             mvLegal_s;
  logic             aiBad_s;
  logic             fiveHit_s;
  logic [CELLS-1:0] chkBoard_s;
  logic [3:0]       runLen_s;
  int               dr_s;
  int               dc_s;

  // Stones of one colour walking away from (r0,c0); stops at the first gap or the board edge,
  // so a row never continues into the next row through the flat bit index.
  function automatic logic [2:0] sideRun(input logic [CELLS-1:0] b, input logic [3:0] r0,
                                         input logic [3:0] c0, input int dr, input int dc);
    logic [2:0] cnt;
    logic       go;
    logic [7:0] idx;
    int         r;
    int         c;
    cnt = 3'd0;
    go  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      r   = int'(r0) + k * dr;
      c   = int'(c0) + k * dc;
      idx = 8'(r * BOARD_N + c);
      if (go && r >= 0 && r < BOARD_N && c >= 0 && c < BOARD_N && b[idx]) begin
        cnt = cnt + 3'd1;
      end else begin
        go = 1'b0;
      end
    end
    return cnt;
  endfunction

  // Move legality, cell indices and saturating stone count.
  always_comb begin
    mvIdx_s   = 8'(mv_x) * 8'(BOARD_N) + 8'(mv_y);
    aiIdx_s   = 8'(ai_x) * 8'(BOARD_N) + 8'(ai_y);
    mvLegal_s = (mv_x <= MAX_RC) && (mv_y <= MAX_RC) && !human_board[mvIdx_s] && !ai_board[mvIdx_s];
    aiBad_s   = (ai_x > MAX_RC) || (ai_y > MAX_RC) || human_board[aiIdx_s];
    if (move_cnt == FULL_CNT) begin
      cntInc_s = move_cnt;
    end else begin
      cntInc_s = move_cnt + 8'd1;
    end
  end

  // Run length through the last stone along the direction selected by dir_r.
  always_comb begin
    dr_s = 0;
    dc_s = 0;
    if (who_r) begin
      chkBoard_s = ai_board;
    end else begin
      chkBoard_s = human_board;
    end
    case (dir_r)
      2'd0:    begin dr_s = 0; dc_s = 1;  end
      2'd1:    begin dr_s = 1; dc_s = 0;  end
      2'd2:    begin dr_s = 1; dc_s = 1;  end
      2'd3:    begin dr_s = 1; dc_s = -1; end
      default: begin dr_s = 0; dc_s = 0;  end
    endcase
    runLen_s  = 4'd1 + {1'b0, sideRun(chkBoard_s, last_x, last_y, dr_s, dc_s)}
                     + {1'b0, sideRun(chkBoard_s, last_x, last_y, -dr_s, -dc_s)};
    fiveHit_s = (runLen_s >= 4'd5);
  end

  // Game FSM; every output is a register set on the transition into the state that owns it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      dir_r       <= 2'd0;
      who_r       <= 1'b0;
      toCnt_r     <= 12'd0;
      human_board <= '0;
      move_cnt    <= 8'd0;
      winner      <= 2'b00;
      game_over   <= 1'b0;
      err         <= 1'b0;
      mv_ready    <= 1'b0;
      mv_reject   <= 1'b0;
      ai_en       <= 1'b0;
      ai_rst_n    <= 1'b1;
      last_x      <= 4'd0;
      last_y      <= 4'd0;
    end else begin
      mv_reject <= 1'b0;
      if (start && state_r != AI_RST) begin
        state_r     <= AI_RST;
        ai_rst_n    <= 1'b0;
        ai_en       <= 1'b0;
        mv_ready    <= 1'b0;
        game_over   <= 1'b0;
        human_board <= '0;
        move_cnt    <= 8'd0;
        winner      <= 2'b00;
        err         <= 1'b0;
      end else begin
        case (state_r)
          IDLE: state_r <= IDLE;
          AI_RST: begin
            ai_rst_n <= 1'b1;
            ai_en    <= 1'b1;
            state_r  <= AI_ARM;
          end
          AI_ARM: begin
            toCnt_r <= 12'd0;
            state_r <= AI_WAIT;
          end
          AI_WAIT: begin
            toCnt_r <= toCnt_r + 12'd1;
            if (ai_finish) begin
              last_x <= ai_x;
              last_y <= ai_y;
              ai_en  <= 1'b0;
              if (aiBad_s) begin
                err       <= 1'b1;
                winner    <= 2'b00;
                game_over <= 1'b1;
                state_r   <= OVER;
              end else begin
                move_cnt <= cntInc_s;
                who_r    <= 1'b1;
                dir_r    <= 2'd0;
                state_r  <= CHK;
              end
            end else if (toCnt_r == 12'(AI_TIMEOUT - 1)) begin
              ai_en     <= 1'b0;
              err       <= 1'b1;
              winner    <= 2'b00;
              game_over <= 1'b1;
              state_r   <= OVER;
            end
          end
          HUM_WAIT: begin
            if (mv_valid) begin
              if (mvLegal_s) begin
                human_board[mvIdx_s] <= 1'b1;
                last_x   <= mv_x;
                last_y   <= mv_y;
                move_cnt <= cntInc_s;
                who_r    <= 1'b0;
                dir_r    <= 2'd0;
                mv_ready <= 1'b0;
                state_r  <= CHK;
              end else begin
                mv_reject <= 1'b1;
              end
            end
          end
          CHK: begin
            if (fiveHit_s) begin
              winner    <= who_r ? 2'b10 : 2'b01;
              game_over <= 1'b1;
              state_r   <= OVER;
            end else if (dir_r == 2'd3) begin
              if (move_cnt == FULL_CNT) begin
                winner    <= 2'b11;
                game_over <= 1'b1;
                state_r   <= OVER;
              end else if (who_r) begin
                mv_ready <= 1'b1;
                state_r  <= HUM_WAIT;
              end else begin
                ai_en   <= 1'b1;
                state_r <= AI_ARM;
              end
            end else begin
              dir_r <= dir_r + 2'd1;
            end
          end
          OVER:    state_r <= OVER;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gobang_turn_ctrl.sv
// Directed bench for gobang_turn_ctrl: the bench plays the engine and the human side,
// inputs change and outputs are sampled on the falling clock edge.
module tb_gobang_turn_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mv_valid;
  logic [3:0]   mv_x;
  logic [3:0]   mv_y;
  logic         mv_ready;
  logic         mv_reject;
  logic [224:0] human_board;
  logic [224:0] ai_board;
  logic         ai_rst_n;
  logic         ai_en;
  logic         ai_finish;
  logic [3:0]   ai_x;
  logic [3:0]   ai_y;
  logic [3:0]   last_x;
  logic [3:0]   last_y;
  logic [7:0]   move_cnt;
  logic [1:0]   winner;
  logic         game_over;
  logic         err;

  int   vecCnt  = 0;
  int   missCnt = 0;
  logic aborted = 1'b0;

  gobang_turn_ctrl #(.AI_TIMEOUT(2048), .BOARD_N(15)) dut (
    .clk(clk), .reset(reset), .start(start), .mv_valid(mv_valid), .mv_x(mv_x), .mv_y(mv_y),
    .mv_ready(mv_ready), .mv_reject(mv_reject), .human_board(human_board), .ai_board(ai_board),
    .ai_rst_n(ai_rst_n), .ai_en(ai_en), .ai_finish(ai_finish), .ai_x(ai_x), .ai_y(ai_y),
    .last_x(last_x), .last_y(last_y), .move_cnt(move_cnt), .winner(winner),
    .game_over(game_over), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic waitReady();
    int i = 0;
    while (!mv_ready && !game_over && i < 2200) begin @(negedge clk); i++; end
    if (!mv_ready) begin
      vecCnt++; missCnt++; aborted = 1'b1;
      $display("FAIL wait_mv_ready got game_over=%0b after %0d cycles, required mv_ready=1", game_over, i);
    end
  endtask

  task automatic waitAiEn();
    int i = 0;
    while (!ai_en && !game_over && i < 2200) begin @(negedge clk); i++; end
    if (!ai_en) begin
      vecCnt++; missCnt++; aborted = 1'b1;
      $display("FAIL wait_ai_en got game_over=%0b after %0d cycles, required ai_en=1", game_over, i);
    end
  endtask

  // Engine model: waits for enable, answers one cycle later so the answer lands in AI_WAIT.
  task automatic aiPlay(input int x, input int y);
    if (aborted) return;
    waitAiEn();
    if (aborted) return;
    @(negedge clk);
    ai_x = 4'(x); ai_y = 4'(y); ai_finish = 1'b1;
    ai_board[x*15+y] = 1'b1;
    @(negedge clk);
    ai_finish = 1'b0;
  endtask

  task automatic humPlay(input int x, input int y);
    if (aborted) return;
    waitReady();
    if (aborted) return;
    mv_valid = 1'b1; mv_x = 4'(x); mv_y = 4'(y);
    @(negedge clk);
    mv_valid = 1'b0;
  endtask

  task automatic newGame();
    @(negedge clk);
    start = 1'b1; ai_board = '0;
    @(negedge clk);
    start = 1'b0; aborted = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mv_valid = 1'b0; mv_x = 4'd0; mv_y = 4'd0;
    ai_board = '0; ai_finish = 1'b0; ai_x = 4'd0; ai_y = 4'd0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    vecCnt++;
    if ({mv_ready, mv_reject, ai_rst_n, ai_en, game_over, err, winner} !== 8'b0010_0000) begin
      missCnt++; $display("FAIL reset_flags got %b required 00100000", {mv_ready, mv_reject, ai_rst_n, ai_en, game_over, err, winner});
    end
    vecCnt++;
    if ({human_board, move_cnt, last_x, last_y} !== '0) begin
      missCnt++; $display("FAIL reset_data got board=%h cnt=%0d last=(%0d,%0d) required zeros", human_board, move_cnt, last_x, last_y);
    end
    reset = 1'b1;
    mv_valid = 1'b1; mv_x = 4'd3; mv_y = 4'd3;
    repeat (2) @(negedge clk);
    mv_valid = 1'b0;
    vecCnt++;
    if ({human_board, move_cnt, mv_reject, ai_en} !== '0) begin
      missCnt++; $display("FAIL idle_ignores_move got board=%h cnt=%0d rej=%0b en=%0b required zeros", human_board, move_cnt, mv_reject, ai_en);
    end
  endtask

  task automatic test_ai_open();
    newGame();
    vecCnt++;
    if ({ai_rst_n, ai_en} !== 2'b00) begin
      missCnt++; $display("FAIL ai_rst_phase got rst_n,en=%b required 00", {ai_rst_n, ai_en});
    end
    @(negedge clk);
    vecCnt++;
    if ({ai_rst_n, ai_en} !== 2'b11) begin
      missCnt++; $display("FAIL ai_arm_phase got rst_n,en=%b required 11", {ai_rst_n, ai_en});
    end
    aiPlay(7, 7);
    vecCnt++;
    if (ai_en !== 1'b0) begin
      missCnt++; $display("FAIL ai_en_drop got %0b required 0", ai_en);
    end
    waitReady();
    vecCnt++;
    if ({last_x, last_y, move_cnt, mv_ready} !== {4'd7, 4'd7, 8'd1, 1'b1}) begin
      missCnt++; $display("FAIL ai_open got last=(%0d,%0d) cnt=%0d ready=%0b required (7,7) 1 1", last_x, last_y, move_cnt, mv_ready);
    end
  endtask

  task automatic test_human_moves();
    logic early = 1'b0;
    humPlay(7, 7);
    vecCnt++;
    if ({mv_reject, mv_ready, move_cnt, human_board} !== {1'b1, 1'b1, 8'd1, 225'd0}) begin
      missCnt++; $display("FAIL reject_occupied got rej=%0b ready=%0b cnt=%0d required 1 1 1", mv_reject, mv_ready, move_cnt);
    end
    @(negedge clk);
    vecCnt++;
    if (mv_reject !== 1'b0) begin
      missCnt++; $display("FAIL reject_pulse_len got %0b required 0", mv_reject);
    end
    humPlay(15, 3);
    vecCnt++;
    if ({mv_reject, mv_ready, move_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      missCnt++; $display("FAIL reject_offboard got rej=%0b ready=%0b cnt=%0d required 1 1 1", mv_reject, mv_ready, move_cnt);
    end
    humPlay(3, 3);
    vecCnt++;
    if ({human_board[48], move_cnt, last_x, last_y, mv_ready, mv_reject} !== {1'b1, 8'd2, 4'd3, 4'd3, 1'b0, 1'b0}) begin
      missCnt++; $display("FAIL accept_3_3 got bit48=%0b cnt=%0d last=(%0d,%0d) ready=%0b rej=%0b required 1 2 (3,3) 0 0",
                          human_board[48], move_cnt, last_x, last_y, mv_ready, mv_reject);
    end
    // Four CHK cycles follow acceptance, so enable shows on the fourth falling edge after it.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ai_en) early = 1'b1;
    end
    @(negedge clk);
    vecCnt++;
    if ({early, ai_en} !== 2'b01) begin
      missCnt++; $display("FAIL ai_en_latency got early=%0b en=%0b required 0 1", early, ai_en);
    end
  endtask

  task automatic test_human_win();
    int hc[5] = '{10, 11, 12, 13, 14};
    int ac[4] = '{0, 2, 4, 6};
    newGame();
    aiPlay(7, 7);
    for (int i = 0; i < 5; i++) begin
      humPlay(0, hc[i]);
      if (i < 4) aiPlay(14, ac[i]);
    end
    vecCnt++;
    if (game_over !== 1'b0) begin
      missCnt++; $display("FAIL row_win_too_early got game_over=%0b required 0", game_over);
    end
    @(negedge clk);
    vecCnt++;
    if ({game_over, winner, move_cnt, mv_ready} !== {1'b1, 2'b01, 8'd10, 1'b0}) begin
      missCnt++; $display("FAIL row_win got over=%0b winner=%b cnt=%0d ready=%0b required 1 01 10 0", game_over, winner, move_cnt, mv_ready);
    end
  endtask

  task automatic test_no_wrap();
    int hr[5] = '{1, 1, 0, 0, 0};
    int hc[5] = '{0, 1, 12, 13, 14};
    int ac[4] = '{0, 2, 4, 6};
    logic [224:0] expB = '0;
    newGame();
    aiPlay(7, 7);
    for (int i = 0; i < 5; i++) begin
      humPlay(hr[i], hc[i]);
      expB[hr[i]*15 + hc[i]] = 1'b1;
      if (i < 4) aiPlay(14, ac[i]);
    end
    waitAiEn();
    vecCnt++;
    if ({game_over, winner, move_cnt} !== {1'b0, 2'b00, 8'd10}) begin
      missCnt++; $display("FAIL no_wrap got over=%0b winner=%b cnt=%0d required 0 00 10", game_over, winner, move_cnt);
    end
    vecCnt++;
    if (human_board !== expB) begin
      missCnt++; $display("FAIL no_wrap_board got %h required %h", human_board, expB);
    end
  endtask

  task automatic test_ai_antidiag();
    int ar[5] = '{2, 3, 4, 5, 6};
    logic early = 1'b0;
    newGame();
    aiPlay(7, 7);
    for (int i = 0; i < 5; i++) begin
      humPlay(10, 2*i);
      aiPlay(ar[i], 8 - ar[i]);
    end
    for (int k = 0; k < 4; k++) begin
      if (game_over) early = 1'b1;
      @(negedge clk);
    end
    vecCnt++;
    if ({early, game_over, winner, move_cnt, err} !== {1'b0, 1'b1, 2'b10, 8'd11, 1'b0}) begin
      missCnt++; $display("FAIL anti_diag_win got early=%0b over=%0b winner=%b cnt=%0d err=%0b required 0 1 10 11 0",
                          early, game_over, winner, move_cnt, err);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    newGame();
    // Back in AI_RST here: one AI_RST cycle, one AI_ARM cycle, then 2048 AI_WAIT cycles.
    while (!game_over && cnt < 2200) begin @(negedge clk); cnt++; end
    vecCnt++;
    if (cnt !== 2050) begin
      missCnt++; $display("FAIL timeout_cycles got %0d required 2050", cnt);
    end
    vecCnt++;
    if ({err, game_over, winner, ai_en} !== {1'b1, 1'b1, 2'b00, 1'b0}) begin
      missCnt++; $display("FAIL timeout_state got err=%0b over=%0b winner=%b en=%0b required 1 1 00 0", err, game_over, winner, ai_en);
    end
    newGame();
    @(negedge clk);
    vecCnt++;
    if ({err, game_over} !== 2'b00) begin
      missCnt++; $display("FAIL start_clears_err got err=%0b over=%0b required 0 0", err, game_over);
    end
  endtask

  task automatic test_stale_restart();
    @(negedge clk);
    ai_finish = 1'b1; ai_x = 4'd15; ai_y = 4'd15;
    newGame();
    waitAiEn();
    @(negedge clk);
    ai_finish = 1'b0;
    vecCnt++;
    if ({err, game_over, ai_en, move_cnt} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
      missCnt++; $display("FAIL stale_finish got err=%0b over=%0b en=%0b cnt=%0d required 0 0 1 0", err, game_over, ai_en, move_cnt);
    end
    aiPlay(7, 7);
    humPlay(0, 0);
    waitAiEn();
    repeat (3) @(negedge clk);
    start = 1'b1; mv_valid = 1'b1; mv_x = 4'd1; mv_y = 4'd1;
    @(negedge clk);
    start = 1'b0; mv_valid = 1'b0; ai_board = '0;
    vecCnt++;
    if ({ai_rst_n, move_cnt, human_board} !== {1'b0, 8'd0, 225'd0}) begin
      missCnt++; $display("FAIL restart_mid_wait got rst_n=%0b cnt=%0d board=%h required 0 0 0", ai_rst_n, move_cnt, human_board);
    end
    aiPlay(7, 7);
    waitReady();
    vecCnt++;
    if ({move_cnt, human_board, mv_ready} !== {8'd1, 225'd0, 1'b1}) begin
      missCnt++; $display("FAIL restart_replay got cnt=%0d board=%h ready=%0b required 1 0 1", move_cnt, human_board, mv_ready);
    end
  endtask

  // Colour (r,c) by ((c + 2r) mod 4) < 2: runs never exceed two in any direction,
  // giving 113 AI cells (including the centre) and 112 human cells.
  task automatic test_draw();
    int aq[$];
    int hq[$];
    int i = 0;
    logic [224:0] expB = '0;
    aq.push_back(7*15 + 7);
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 15; c++) begin
        if (!(r == 7 && c == 7)) begin
          if (((c + 2*r) % 4) < 2) aq.push_back(r*15 + c);
          else begin hq.push_back(r*15 + c); expB[r*15 + c] = 1'b1; end
        end
      end
    end
    newGame();
    for (int m = 0; m < 113; m++) begin
      aiPlay(aq[m] / 15, aq[m] % 15);
      if (m < 112) humPlay(hq[m] / 15, hq[m] % 15);
      if (aborted) break;
    end
    while (!game_over && i < 50) begin @(negedge clk); i++; end
    vecCnt++;
    if ({game_over, winner, move_cnt, err} !== {1'b1, 2'b11, 8'd225, 1'b0}) begin
      missCnt++; $display("FAIL draw got over=%0b winner=%b cnt=%0d err=%0b required 1 11 225 0", game_over, winner, move_cnt, err);
    end
    vecCnt++;
    if (human_board !== expB) begin
      missCnt++; $display("FAIL draw_board got %h required %h", human_board, expB);
    end
  endtask

  task automatic test_reset_mid();
    newGame();
    aiPlay(7, 7);
    humPlay(2, 2);
    waitAiEn();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vecCnt++;
    if ({ai_en, ai_rst_n, mv_ready, game_over, move_cnt, last_x, last_y, human_board} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 225'd0}) begin
      missCnt++; $display("FAIL async_reset_mid got en=%0b rst_n=%0b ready=%0b over=%0b cnt=%0d last=(%0d,%0d) required 0 1 0 0 0 (0,0)",
                          ai_en, ai_rst_n, mv_ready, game_over, move_cnt, last_x, last_y);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ai_open();
    test_human_moves();
    test_human_win();
    test_no_wrap();
    test_ai_antidiag();
    test_timeout();
    test_stale_restart();
    test_draw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
